// File: rtl/multicycle_alu_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_alu_pkg
// Shared definitions for the multi-cycle ALU: operand width, iteration count,
// ALUcont operation codes, FSM state encoding and a small decode helper.
// -----------------------------------------------------------------------------
package multicycle_alu_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_MUL = 4'h3;
    localparam logic [3:0] ALU_DIV = 4'h4;
    localparam logic [3:0] ALU_SUB = 4'h6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // MUL always iterates; DIV iterates only when the divisor is non-zero,
    // otherwise it takes the single-cycle divide-by-zero path.
    function automatic logic is_iter_op(input logic [3:0] op, input logic b_nonzero);
        logic iter;
        case (op)
            ALU_MUL: iter = 1'b1;
            ALU_DIV: iter = b_nonzero;
            default: iter = 1'b0;
        endcase
        return iter;
    endfunction

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative datapath shared by MUL (shift-add) and DIV (restoring division).
// One bit is processed per i_step cycle; after ITER_COUNT steps the pair
// {o_hi, o_lo} holds {high product, low product} or {remainder, quotient}.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : capture operands and clear the iteration counter
//   i_is_div   : 1 = divide, 0 = multiply (captured on i_load)
//   i_a, i_b   : operands (A = multiplicand/dividend, B = multiplier/divisor)
//   i_step     : perform one iteration
//   o_last     : counter is on its final iteration
//   o_lo, o_hi : working registers / final result
// -----------------------------------------------------------------------------
module muldiv_iter
    import multicycle_alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_is_div,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_step,
    output logic         o_last,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_m;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;

    logic [W:0]       w_sum;
    logic [W:0]       w_rem_sh;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_hi_nxt;
    logic [W-1:0]     w_lo_nxt;

    // Single iteration step for either operation.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(W+1){1'b0}});
        w_rem_sh = {r_hi, r_lo[W-1]};
        w_diff   = w_rem_sh - {1'b0, r_m};
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            // Restoring division: a borrow (MSB set) means the trial subtract
            // failed, so keep the shifted remainder and shift in a 0.
            if (!w_diff[W]) begin
                w_hi_nxt = w_diff[W-1:0];
                w_lo_nxt = {r_lo[W-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rem_sh[W-1:0];
                w_lo_nxt = {r_lo[W-2:0], 1'b0};
            end
        end else begin
            // Shift-add: the carry out of the partial sum enters hi's MSB,
            // and the sum's LSB becomes the next product bit in lo.
            w_hi_nxt = w_sum[W:1];
            w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end
    end

    // Working registers and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_a : i_b;
            r_m      <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(ITER_COUNT - 1));
    assign o_lo   = r_lo;
    assign o_hi   = r_hi;

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// ALU with single-cycle AND/OR/ADD/SUB and iterative 32-cycle MUL/DIV.
// Single-cycle ops complete on the edge after accept without leaving IDLE;
// MUL/DIV go IDLE -> ITER (32 steps) -> DONE and complete on the 33rd edge.
//
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   start    : operation request, accepted when busy=0
//   ALUcont  : operation code (see multicycle_alu_pkg)
//   A, B     : operands
//   result   : primary result (low product / quotient)
//   hi       : secondary result (high product / remainder, else 0)
//   zero     : result == 0
//   busy     : MUL/DIV in progress
//   done     : one-cycle pulse when result/hi/zero/div_zero update
//   div_zero : completed op was DIV with B == 0
// -----------------------------------------------------------------------------
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = multicycle_alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUcont,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t           r_state;
    state_t           w_next;

    logic             r_pend;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_iter;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_div_zero;

    assign w_accept = start & ~r_busy;
    assign w_iter   = is_iter_op(ALUcont, (B != '0));
    assign w_load   = w_accept & w_iter;
    assign w_step   = (r_state == ITER);

    muldiv_iter #(
        .W(WIDTH)
    ) u_muldiv_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_is_div (ALUcont == ALU_DIV),
        .i_a      (A),
        .i_b      (B),
        .i_step   (w_step),
        .o_last   (w_last),
        .o_lo     (w_md_lo),
        .o_hi     (w_md_hi)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_next = ITER;
                end else begin
                    w_next = IDLE;
                end
            end
            ITER: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = ITER;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the accepted single-cycle operation for completion on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_op   <= 4'h0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (w_accept) begin
            r_pend <= ~w_iter;
            r_op   <= ALUcont;
            r_a    <= A;
            r_b    <= B;
        end else begin
            r_pend <= 1'b0;
        end
    end

    // Single-cycle result from the latched operands.
    always_comb begin
        w_sc_result   = '0;
        w_sc_hi       = '0;
        w_sc_div_zero = 1'b0;
        case (r_op)
            ALU_AND: w_sc_result = r_a & r_b;
            ALU_OR:  w_sc_result = r_a | r_b;
            ALU_ADD: w_sc_result = r_a + r_b;
            ALU_SUB: w_sc_result = r_a - r_b;
            ALU_DIV: begin
                // Only reachable with B == 0: saturated quotient, dividend as remainder.
                w_sc_result   = {WIDTH{1'b1}};
                w_sc_hi       = r_a;
                w_sc_div_zero = 1'b1;
            end
            default: begin
                w_sc_result = '0;
                w_sc_hi     = '0;
            end
        endcase
    end

    // Output registers; they only change on a completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_hi       <= '0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (r_state == DONE) begin
            r_result   <= w_md_lo;
            r_hi       <= w_md_hi;
            r_zero     <= (w_md_lo == '0);
            r_done     <= 1'b1;
            r_div_zero <= 1'b0;
        end else if (r_pend) begin
            r_result   <= w_sc_result;
            r_hi       <= w_sc_hi;
            r_zero     <= (w_sc_result == '0);
            r_done     <= 1'b1;
            r_div_zero <= w_sc_div_zero;
        end else begin
            r_done <= 1'b0;
        end
    end

    // Busy spans from accept of an iterative op until its completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (w_load) begin
            r_busy <= 1'b1;
        end else if (r_state == DONE) begin
            r_busy <= 1'b0;
        end
    end

    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
// Directed, table-driven bench for multicycle_alu. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alucont;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    multicycle_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ALUcont  (alucont),
        .A        (a),
        .B        (b),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the completion falling edge.
    task automatic run_single(input vec_t v);
        start   = 1'b1;
        alucont = v.op;
        a       = v.a;
        b       = v.b;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hA5A5_5A5A;
        b     = 32'h0000_0000;
        chk({v.name, "_accept_busy_done"}, {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        chk({v.name, "_done_busy"}, {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
        chk({v.name, "_result_hi"}, {result, hi}, {v.r, v.h});
        chk({v.name, "_zero_dz"}, {62'd0, zero, div_zero}, {62'd0, v.z, v.dz});
    endtask

    // Iterative op; optionally injects an ADD start at cycle inject, or
    // asserts reset at cycle rst_at (then returns without expecting done).
    task automatic run_iter(input string nm, input logic [3:0] op,
                            input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] er, input logic [31:0] eh,
                            input int inject, input int rst_at);
        int bad;
        bad     = 0;
        start   = 1'b1;
        alucont = op;
        a       = av;
        b       = bv;
        @(negedge clk);
        start   = 1'b0;
        alucont = ALU_SUB;
        a       = 32'hDEAD_BEEF;
        b       = 32'h0000_0000;
        chk({nm, "_accept_busy_done"}, {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk({nm, "_reset_outputs"},
                    {result, hi[26:0], zero, busy, done, div_zero, 1'b0}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == inject) begin
                start   = 1'b1;
                alucont = ALU_ADD;
                a       = 32'd1;
                b       = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (done !== 1'b0 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        chk({nm, "_busy_window"}, 64'(bad), 64'd0);
        @(negedge clk);
        chk({nm, "_done_busy"}, {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
        chk({nm, "_result_hi"}, {result, hi}, {er, eh});
        chk({nm, "_zero_dz"}, {62'd0, zero, div_zero}, {62'd0, (er == 32'd0), 1'b0});
    endtask

    initial begin
        int spurious;
        vecs[0] = '{"add_wrap",   ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0};
        vecs[1] = '{"sub_neg",    ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{"and",        ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0};
        vecs[3] = '{"or",         ALU_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'h0, 1'b0, 1'b0};
        vecs[4] = '{"undef5",     4'h5,    32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{"div_by_0",   ALU_DIV, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 32'h9, 1'b0, 1'b1};
        vecs[6] = '{"add_plain",  ALU_ADD, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 32'h0, 1'b0, 1'b0};
        vecs[7] = '{"sub_equal",  ALU_SUB, 32'h8000_0001, 32'h8000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0};
        vecs[8] = '{"undefF",     4'hF,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b1, 1'b0};
        vecs[9] = '{"add_msb",    ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        alucont = 4'h0;
        a       = 32'd0;
        b       = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", {result, hi[26:0], zero, busy, done, div_zero, 1'b0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_single(vecs[i]);

        run_iter("mul_max",  ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0);
        // Back-to-back: this start is accepted in the cycle done is high.
        run_iter("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
        run_single('{"div_by_0_9", ALU_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1});
        run_iter("mul_2p32", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 0, 0);
        run_iter("div_by_1", ALU_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 0, 0);
        run_iter("div_small", ALU_DIV, 32'd5, 32'd7, 32'd0, 32'd5, 0, 0);
        run_iter("mul_inject", ALU_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 10, 0);

        // Abort a DIV mid-flight; no done may follow for it.
        run_iter("div_abort", ALU_DIV, 32'h0000_FFFF, 32'd3, 32'd0, 32'd0, 0, 15);
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        chk("abort_no_done", 64'(spurious), 64'd0);
        run_iter("mul_after_rst", ALU_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 0, 0);

        @(negedge clk);
        chk("final_done_low", {63'd0, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
